// File: rtl/rename_pkg.sv
// Shared rename-stage types.
//   PHYS_W     : physical register tag width
//   MAX_LANES  : rename/dispatch group width
//   dq_entry_t : one queued micro-op (source, destination and previous-destination tags)
//   lane_cnt_t : count of lanes within one group, 0..MAX_LANES inclusive
package rename_pkg;
  localparam int unsigned PHYS_W    = 7;
  localparam int unsigned MAX_LANES = 8;

  typedef struct packed {
    logic [PHYS_W-1:0] rs1;
    logic [PHYS_W-1:0] rs2;
    logic [PHYS_W-1:0] rd;
    logic [PHYS_W-1:0] old_rd;
  } dq_entry_t;

  typedef logic [$clog2(MAX_LANES):0] lane_cnt_t;
endpackage

// File: rtl/lane_compactor_8.sv
// Prefix popcount over an 8-lane sparse valid mask.
//   i_valid  : per-lane valid mask
//   o_offset : per-lane count of valid lanes strictly below it (compacted slot offset)
//   o_count  : total number of valid lanes
module lane_compactor_8
  import rename_pkg::*;
(
  input  logic [MAX_LANES-1:0]            i_valid,
  output lane_cnt_t [MAX_LANES-1:0]       o_offset,
  output lane_cnt_t                       o_count
);

  lane_cnt_t w_acc;

  always_comb begin
    w_acc    = '0;
    o_offset = '0;
    for (int unsigned k = 0; k < MAX_LANES; k++) begin
      o_offset[k] = w_acc;
      w_acc       = w_acc + lane_cnt_t'(i_valid[k]);
    end
    o_count = w_acc;
  end

endmodule

// File: rtl/dispatch_queue_8wide.sv
// Circular micro-op buffer between 8-wide rename and reservation-station dispatch.
//   clk, rst         : clock, asynchronous active-high reset
//   flush_i          : discard all queued entries
//   enq_valid_i      : sparse per-lane enqueue mask
//   enq_*_i          : per-lane physical tags (LANES x PHYS_W, lane k at [k*PHYS_W +: PHYS_W])
//   enq_ready_o      : room for a full group (all-or-nothing)
//   deq_valid_o      : thermometer mask of presented entries
//   deq_*_o          : tags of the k-th oldest entry, zero on invalid lanes
//   deq_take_i       : number of entries consumed this cycle (clamped)
//   count_o          : current occupancy
module dispatch_queue_8wide #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned LANES  = 8,
  parameter int unsigned PHYS_W = rename_pkg::PHYS_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [LANES-1:0]           enq_valid_i,
  input  logic [LANES*PHYS_W-1:0]    enq_rs1_i,
  input  logic [LANES*PHYS_W-1:0]    enq_rs2_i,
  input  logic [LANES*PHYS_W-1:0]    enq_rd_i,
  input  logic [LANES*PHYS_W-1:0]    enq_old_rd_i,
  output logic                       enq_ready_o,
  output logic [LANES-1:0]           deq_valid_o,
  output logic [LANES*PHYS_W-1:0]    deq_rs1_o,
  output logic [LANES*PHYS_W-1:0]    deq_rs2_o,
  output logic [LANES*PHYS_W-1:0]    deq_rd_o,
  output logic [LANES*PHYS_W-1:0]    deq_old_rd_o,
  input  logic [$clog2(LANES):0]     deq_take_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = $clog2(LANES) + 1;

  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [PHYS_W-1:0] r_rs1    [DEPTH];
  logic [PHYS_W-1:0] r_rs2    [DEPTH];
  logic [PHYS_W-1:0] r_rd     [DEPTH];
  logic [PHYS_W-1:0] r_old_rd [DEPTH];

  rename_pkg::lane_cnt_t [LANES-1:0] w_offset;
  rename_pkg::lane_cnt_t             w_popcnt;
  logic [AW-1:0]                     w_wslot [LANES];
  logic [CW-1:0]                     w_free;
  logic                              w_enq_fire;
  logic [CW-1:0]                     w_n_enq;
  logic [CW-1:0]                     w_take;
  logic [CW-1:0]                     w_n_deq;

  lane_compactor_8 u_compact (
    .i_valid  (enq_valid_i),
    .o_offset (w_offset),
    .o_count  (w_popcnt)
  );

  // Readiness uses start-of-cycle occupancy only; a same-cycle dequeue earns no credit.
  always_comb begin
    w_free      = CW'(DEPTH) - r_count;
    enq_ready_o = (w_free >= CW'(LANES));
    w_enq_fire  = enq_ready_o && (|enq_valid_i) && !flush_i;
    w_n_enq     = w_enq_fire ? CW'(w_popcnt) : '0;
    w_take      = (deq_take_i > LW'(LANES)) ? CW'(LANES) : CW'(deq_take_i);
    w_n_deq     = (w_take > r_count) ? r_count : w_take;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_wslot[k] = r_tail + AW'(w_offset[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_n_deq);
      r_tail  <= r_tail + AW'(w_n_enq);
      r_count <= r_count + w_n_enq - w_n_deq;
    end
  end

  // Entry storage carries no reset; stale contents are hidden by the output masking.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (enq_valid_i[k]) begin
          r_rs1[w_wslot[k]]    <= enq_rs1_i[k*PHYS_W +: PHYS_W];
          r_rs2[w_wslot[k]]    <= enq_rs2_i[k*PHYS_W +: PHYS_W];
          r_rd[w_wslot[k]]     <= enq_rd_i[k*PHYS_W +: PHYS_W];
          r_old_rd[w_wslot[k]] <= enq_old_rd_i[k*PHYS_W +: PHYS_W];
        end
      end
    end
  end

  always_comb begin
    deq_valid_o  = '0;
    deq_rs1_o    = '0;
    deq_rs2_o    = '0;
    deq_rd_o     = '0;
    deq_old_rd_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (CW'(k) < r_count) begin
        deq_valid_o[k]                   = 1'b1;
        deq_rs1_o[k*PHYS_W +: PHYS_W]    = r_rs1[r_head + AW'(k)];
        deq_rs2_o[k*PHYS_W +: PHYS_W]    = r_rs2[r_head + AW'(k)];
        deq_rd_o[k*PHYS_W +: PHYS_W]     = r_rd[r_head + AW'(k)];
        deq_old_rd_o[k*PHYS_W +: PHYS_W] = r_old_rd[r_head + AW'(k)];
      end
    end
    count_o = r_count;
  end

endmodule
